// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the parametrised serial adder.
//   sa_state_e     : control FSM states
//   OP_ADD/OP_SUB  : encodings of op_i
//   sa_width_check : legal operand width test (2..32)
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        SEND
    } sa_state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic bit sa_width_check(input int unsigned width);
        return (width >= 2) && (width <= 32);
    endfunction

endpackage

// File: rtl/serial_adder_param_if.sv
// Serial bus between the frame driver/monitor and serial_adder_param.
//   en_i/ina/inb/op_i     : driver -> adder (input frame)
//   en_o/out/busy_o/err_o : adder -> monitor (result frame and status)
// master = driver side, slave = adder side.
interface serial_adder_param_if;

    logic en_i;
    logic ina;
    logic inb;
    logic op_i;
    logic en_o;
    logic out;
    logic busy_o;
    logic err_o;

    modport master (
        output en_i, ina, inb, op_i,
        input  en_o, out, busy_o, err_o
    );

    modport slave (
        input  en_i, ina, inb, op_i,
        output en_o, out, busy_o, err_o
    );

endinterface

// File: rtl/sa_shift_reg.sv
// N-bit shift register with serial input, parallel load/read and synchronous clear.
//   clk       : rising-edge clock
//   clr       : synchronous clear (highest priority)
//   load      : parallel load of load_data
//   load_data : parallel input
//   shift     : shift by one, inserting sin
//   sin       : serial input bit
//   q         : parallel contents
// LSB_FIRST=1 shifts toward bit 0 (serial stream is LSB first, next bit to send is q[0]);
// LSB_FIRST=0 shifts toward bit N-1 (MSB first, next bit to send is q[N-1]).
module sa_shift_reg #(
    parameter int unsigned N         = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         shift,
    input  logic         sin,
    output logic [N-1:0] q
);

    logic [N-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = load_data;
        end else if (shift) begin
            q_d = LSB_FIRST ? {sin, q_q[N-1:1]} : {q_q[N-2:0], sin};
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/serial_adder_param.sv
// Serial adder/subtractor: captures two WIDTH-bit operands serially, then returns the
// WIDTH+1-bit sum or difference serially.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of serial_adder_param_if
//           en_i/ina/inb/op_i in, en_o/out/busy_o/err_o out (all outputs registered)
module serial_adder_param
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_adder_param_if.slave bus
);

    if (!sa_width_check(WIDTH)) begin : g_width_bad
        $error("serial_adder_param: WIDTH must be in 2..32");
    end

    // Counter must reach WIDTH+1: WIDTH+1 result bits plus the closing cycle of SEND.
    localparam int unsigned CntW = $clog2(WIDTH + 2);
    localparam logic [CntW-1:0] LastIn  = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] LastOut = CntW'(WIDTH);

    sa_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            op_q, op_d;
    logic            en_o_q, en_o_d;
    logic            out_q, out_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic             opnd_shift, res_load, res_shift;
    logic [WIDTH-1:0] a_val, b_val;
    logic [WIDTH:0]   a_ext, b_ext, res_val, res_q;
    logic             res_sout;

    sa_shift_reg #(.N(WIDTH), .LSB_FIRST(LSB_FIRST)) u_a_reg (
        .clk       (clk),
        .clr       (!rst_n),
        .load      (1'b0),
        .load_data ('0),
        .shift     (opnd_shift),
        .sin       (bus.ina),
        .q         (a_val)
    );

    sa_shift_reg #(.N(WIDTH), .LSB_FIRST(LSB_FIRST)) u_b_reg (
        .clk       (clk),
        .clr       (!rst_n),
        .load      (1'b0),
        .load_data ('0),
        .shift     (opnd_shift),
        .sin       (bus.inb),
        .q         (b_val)
    );

    // Zero-extended so the top bit is carry (add) or borrow/sign (subtract).
    assign a_ext   = {1'b0, a_val};
    assign b_ext   = {1'b0, b_val};
    assign res_val = (op_q == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);

    sa_shift_reg #(.N(WIDTH + 1), .LSB_FIRST(LSB_FIRST)) u_res_reg (
        .clk       (clk),
        .clr       (!rst_n),
        .load      (res_load),
        .load_data (res_val),
        .shift     (res_shift),
        .sin       (1'b0),
        .q         (res_q)
    );

    assign res_sout = LSB_FIRST ? res_q[0] : res_q[WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        en_o_d     = 1'b0;
        out_d      = 1'b0;
        err_d      = 1'b0;
        opnd_shift = 1'b0;
        res_load   = 1'b0;
        res_shift  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.en_i) begin
                    opnd_shift = 1'b1;
                    op_d       = bus.op_i;
                    cnt_d      = CntW'(1);
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (bus.en_i) begin
                    opnd_shift = 1'b1;
                    if (cnt_q == LastIn) begin
                        cnt_d   = '0;
                        state_d = CALC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // Short frame: drop it and flag the abort.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            CALC: begin
                err_d    = bus.en_i;
                res_load = 1'b1;
                state_d  = SEND;
            end
            SEND: begin
                err_d = bus.en_i;
                if (cnt_q <= LastOut) begin
                    en_o_d    = 1'b1;
                    out_d     = res_sout;
                    res_shift = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
            en_o_q  <= 1'b0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            en_o_q  <= en_o_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.en_o   = en_o_q;
    assign bus.out    = out_q;
    assign bus.busy_o = busy_q;
    assign bus.err_o  = err_q;

endmodule
